// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller reader.
package nes_pkg;

  localparam int NUM_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    CLK_HI,
    CLK_LO,
    DONE
  } state_t;

  // Button positions in the presented byte (scan order, LSB first).
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_phase_timer.sv
// Phase counter for the timed scan states: counts 0..CLK_DIV-1 and flags the last cycle.
module nes_phase_timer #(
  parameter int CLK_DIV = 240
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_last
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [W-1:0] r_cnt;

  assign o_last = (r_cnt == W'(CLK_DIV - 1));

  // Wrapping on o_last doubles as the restart at every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nes_controller_reader.sv
// Polls a 4021-based NES pad: latch, 7 clock pulses, 8 active-low bits in, active-high out.
module nes_controller_reader
  import nes_pkg::*;
#(
  parameter int CLK_DIV     = 240,
  parameter int POLL_PERIOD = 666667
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       c1_data_in,
  input  logic       poll_now,
  output logic       cclk,
  output logic       pulse_out,
  output logic       busy,
  output logic       valid,
  output logic [7:0] buttons,
  output logic [7:0] pressed
);

  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int BW = $clog2(NUM_BITS);

  state_t                r_state;
  logic [PW-1:0]         r_poll_cnt;
  logic                  r_sync1;
  logic                  r_sync2;
  logic [NUM_BITS-1:0]   r_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_latch_half;
  logic                  r_cclk;
  logic                  r_pulse;
  logic                  r_busy;
  logic                  r_valid;
  logic [NUM_BITS-1:0]   r_buttons;
  logic [NUM_BITS-1:0]   r_pressed;

  logic                  w_wrap;
  logic                  w_trigger;
  logic                  w_phase_clear;
  logic                  w_phase_last;
  logic [NUM_BITS-1:0]   w_final;

  assign w_wrap        = (r_poll_cnt == PW'(POLL_PERIOD - 1));
  assign w_trigger     = w_wrap | poll_now;
  assign w_phase_clear = (r_state == IDLE) || (r_state == DONE);
  // Last bit arrives on the same edge that publishes the result.
  assign w_final       = {r_sync2, r_shift[NUM_BITS-2:0]};

  assign cclk      = r_cclk;
  assign pulse_out = r_pulse;
  assign busy      = r_busy;
  assign valid     = r_valid;
  assign buttons   = r_buttons;
  assign pressed   = r_pressed;

  nes_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk     (clk),
    .rst_n   (reset),
    .i_clear (w_phase_clear),
    .o_last  (w_phase_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_poll_cnt <= '0;
    end else if (w_wrap) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= c1_data_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_latch_half <= 1'b0;
      r_cclk       <= 1'b0;
      r_pulse      <= 1'b0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_buttons    <= '0;
      r_pressed    <= '0;
    end else begin
      r_valid   <= 1'b0;
      r_pressed <= '0;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_state      <= LATCH;
            r_pulse      <= 1'b1;
            r_busy       <= 1'b1;
            r_latch_half <= 1'b0;
          end
        end
        LATCH: begin
          // Latch spans two phase periods.
          if (w_phase_last) begin
            if (r_latch_half) begin
              r_state <= SETTLE;
              r_pulse <= 1'b0;
            end else begin
              r_latch_half <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (w_phase_last) begin
            r_shift[0] <= r_sync2;
            r_bit_cnt  <= BW'(1);
            r_state    <= CLK_HI;
            r_cclk     <= 1'b1;
          end
        end
        CLK_HI: begin
          if (w_phase_last) begin
            r_state <= CLK_LO;
            r_cclk  <= 1'b0;
          end
        end
        CLK_LO: begin
          if (w_phase_last) begin
            r_shift[r_bit_cnt] <= r_sync2;
            if (r_bit_cnt == BW'(NUM_BITS - 1)) begin
              r_buttons <= ~w_final;
              r_pressed <= ~w_final & ~r_buttons;
              r_valid   <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_state   <= CLK_HI;
              r_cclk    <= 1'b1;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cclk  <= 1'b0;
          r_pulse <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_controller_reader.sv
// Bench for nes_controller_reader: 4021 pad model plus a scan-timeline reference model.
module tb_nes_controller_reader;

  localparam int D  = 4;
  localparam int PP = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic       c1_data_in;
  logic       poll_now;
  logic       cclk;
  logic       pulse_out;
  logic       busy;
  logic       valid;
  logic [7:0] buttons;
  logic [7:0] pressed;

  int checks = 0;
  int errors = 0;
  int tcnt   = 0;

  logic [7:0] pad = 8'h00;
  logic [7:0] last_btn = 8'h00;
  logic [7:0] sr = 8'hFF;
  bit         noise_en = 1'b0;
  bit         glitch = 1'b0;

  int         m_timer = 0;
  int         m_k = 0;
  bit         m_active = 1'b0;
  logic [7:0] m_buttons = 8'h00;
  logic [7:0] m_pressed = 8'h00;
  logic [7:0] m_cap = 8'h00;

  nes_controller_reader #(
    .CLK_DIV     (D),
    .POLL_PERIOD (PP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .c1_data_in (c1_data_in),
    .poll_now   (poll_now),
    .cclk       (cclk),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .valid      (valid),
    .buttons    (buttons),
    .pressed    (pressed)
  );

  always #5 clk = ~clk;

  // 4021 pad: parallel load on latch rise, shift toward the output on clock rise.
  always @(posedge cclk or posedge pulse_out) begin
    if (pulse_out) sr <= ~pad;
    else           sr <= {1'b1, sr[7:1]};
  end

  assign c1_data_in = sr[0] ^ glitch;

  // Line noise confined to clock-high phases, where nothing is sampled.
  initial forever begin
    #($urandom_range(4, 1));
    glitch = (noise_en && cclk) ? ~glitch : 1'b0;
  end

  // Reference timeline: m_k is the cycle index relative to the accepted trigger cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_timer   <= 0;
      m_active  <= 1'b0;
      m_k       <= 0;
      m_buttons <= 8'h00;
      m_pressed <= 8'h00;
    end else begin
      m_timer <= (m_timer == PP - 1) ? 0 : m_timer + 1;
      if (!m_active && ((m_timer == PP - 1) || poll_now)) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_cap    <= pad;
      end else if (m_active) begin
        if (m_k == 17 * D + 1) m_active <= 1'b0;
        m_k <= m_k + 1;
        if (m_k == 17 * D) begin
          m_buttons <= m_cap;
          m_pressed <= m_cap & ~m_buttons;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit         e_pulse, e_cclk, e_busy, e_valid;
    logic [7:0] e_prs;
    @(negedge clk);
    tcnt++;
    e_busy  = m_active;
    e_pulse = m_active && (m_k <= 2 * D);
    e_cclk  = m_active && (m_k >= 3 * D + 1) && (m_k <= 16 * D) &&
              ((((m_k - 3 * D - 1) / D) % 2) == 0);
    e_valid = m_active && (m_k == 17 * D + 1);
    e_prs   = e_valid ? m_pressed : 8'h00;
    chk("cycle{pulse,cclk,busy,valid,buttons,pressed}",
        {12'h0, pulse_out, cclk, busy, valid, buttons, pressed},
        {12'h0, e_pulse, e_cclk, e_busy, e_valid, m_buttons, e_prs});
  endtask

  task automatic pulse_poll();
    poll_now = 1'b1;
    tick();
    poll_now = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("valid_timeout", {31'h0, ok}, 32'h1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_active && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic scan_once(input logic [7:0] p, input string tag);
    bit ok;
    wait_idle();
    pad = p;
    pulse_poll();
    wait_valid(100, ok);
    chk({tag, "_buttons"}, {24'h0, buttons}, {24'h0, p});
    chk({tag, "_pressed"}, {24'h0, pressed}, {24'h0, p & ~last_btn});
    last_btn = p;
  endtask

  initial begin
    int  t0, pf, pl, bf, bl, rises, run, runbad, vc, vi, n;
    bit  prev_cclk, ok;
    logic [7:0] vbtn, vprs, rp;

    reset    = 1'b0;
    poll_now = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tcnt  = 0;
    repeat (3) tick();

    // Scan timing from a poll_now request, pad fully released.
    t0 = tcnt; pf = -1; pl = -1; bf = -1; bl = -1;
    rises = 0; run = 0; runbad = 0; vc = 0; vi = -1; prev_cclk = 1'b0;
    vbtn = 8'hFF; vprs = 8'hFF;
    poll_now = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (i == 0) poll_now = 1'b0;
      if (pulse_out) begin if (pf < 0) pf = tcnt; pl = tcnt; end
      if (busy)      begin if (bf < 0) bf = tcnt; bl = tcnt; end
      if (cclk && !prev_cclk) rises++;
      if (cclk) run++;
      else if (prev_cclk) begin
        if (run != D) runbad++;
        run = 0;
      end
      prev_cclk = cclk;
      if (valid) begin vc++; vi = tcnt; vbtn = buttons; vprs = pressed; end
    end
    chk("t1_latch_first", 32'(pf), 32'(t0 + 1));
    chk("t1_latch_last",  32'(pl), 32'(t0 + 2 * D));
    chk("t1_cclk_pulses", 32'(rises), 32'd7);
    chk("t1_cclk_width_bad", 32'(runbad), 32'd0);
    chk("t1_valid_count", 32'(vc), 32'd1);
    chk("t1_valid_cycle", 32'(vi), 32'(t0 + 17 * D + 1));
    chk("t1_busy_first",  32'(bf), 32'(t0 + 1));
    chk("t1_busy_last",   32'(bl), 32'(t0 + 17 * D + 1));
    chk("t2_buttons", {24'h0, vbtn}, 32'h0);
    chk("t2_pressed", {24'h0, vprs}, 32'h0);

    // Press events: new, held, and changed buttons.
    scan_once(8'h81, "t3_a_right");
    scan_once(8'h81, "t3_held");
    scan_once(8'h88, "t3_start");

    // Request during CLK_HI is dropped.
    n = 0;
    while (!(m_timer == 0 && !m_active) && n < 450) begin tick(); n++; end
    pulse_poll();
    n = 0;
    while (!(m_active && m_k == 3 * D + 2) && n < 50) begin tick(); n++; end
    chk("t4_in_clk_hi", {31'h0, cclk}, 32'h1);
    pulse_poll();
    wait_valid(100, ok);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_second_scan", {31'h0, busy}, 32'h0);
    end

    // poll_now coincident with timer wrap yields a single scan.
    n = 0;
    while (!(m_timer == PP - 1 && !m_active) && n < 250) begin tick(); n++; end
    chk("t4_at_wrap", 32'(m_timer), 32'(PP - 1));
    pulse_poll();
    vc = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (valid) vc++;
    end
    chk("t4_single_valid", 32'(vc), 32'd1);

    // Reset during bit 3.
    wait_idle();
    pulse_poll();
    n = 0;
    while (!(m_active && m_k == 7 * D + 2) && n < 60) begin tick(); n++; end
    #2 reset = 1'b0;
    #1;
    chk("t5_async_clear", {20'h0, cclk, pulse_out, busy, valid, buttons},
        {20'h0, 4'b0000, 8'h00});
    chk("t5_async_pressed", {24'h0, pressed}, 32'h0);
    repeat (3) tick();
    reset    = 1'b1;
    tcnt     = 0;
    last_btn = 8'h00;
    pf = -1; vc = 0;
    for (int i = 0; i < 250 && pf < 0; i++) begin
      tick();
      if (valid) vc++;
      if (pulse_out) pf = tcnt;
    end
    chk("t5_first_latch_after_reset", 32'(pf), 32'(PP));
    chk("t5_no_valid_before", 32'(vc), 32'd0);
    wait_valid(100, ok);
    chk("t5_buttons", {24'h0, buttons}, {24'h0, pad});
    last_btn = pad;

    // Random pads with asynchronous line noise between samples.
    noise_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rp = 8'($urandom);
      scan_once(rp, "t6_noise");
    end
    noise_en = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
